// File: rtl/icache_refill_responder.sv
// ICache refill responder: takes one line miss, fetches it beat by beat
// from a narrow memory port, and returns the assembled line with paddr/way.
//
// Ports:
//  clk_i, rst_ni                        clock / async active-low reset
//  miss_req_valid_i/ready_o/paddr_i/
//    victim_way_i/index_i               miss request from the frontend
//  refill_valid_o/ready_i/paddr_o/
//    way_o/data_o                       refill line back to the ICache
//  mem_req_valid_o/ready_i/addr_o       memory beat read request
//  mem_rsp_valid_i/data_i               memory beat read data
//  busy_o                               high whenever a miss is in flight
module icache_refill_responder #(
  parameter int PLEN    = 32,
  parameter int LINE_W  = 256,
  parameter int WAY_W   = 2,
  parameter int INDEX_W = 6,
  parameter int MEM_DW  = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               miss_req_valid_i,
  output logic               miss_req_ready_o,
  input  logic [PLEN-1:0]    miss_req_paddr_i,
  input  logic [WAY_W-1:0]   miss_req_victim_way_i,
  input  logic [INDEX_W-1:0] miss_req_index_i,
  output logic               refill_valid_o,
  input  logic               refill_ready_i,
  output logic [PLEN-1:0]    refill_paddr_o,
  output logic [WAY_W-1:0]   refill_way_o,
  output logic [LINE_W-1:0]  refill_data_o,
  output logic               mem_req_valid_o,
  input  logic               mem_req_ready_i,
  output logic [PLEN-1:0]    mem_req_addr_o,
  input  logic               mem_rsp_valid_i,
  input  logic [MEM_DW-1:0]  mem_rsp_data_i,
  output logic               busy_o
);

  localparam int BEATS = LINE_W / MEM_DW;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LB    = $clog2(LINE_W / 8);
  localparam int BB    = $clog2(MEM_DW / 8);
  localparam logic [BW-1:0] LAST = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } state_e;

  state_e            state_q;
  logic [BW-1:0]     beat_q;
  logic [BW-1:0]     beat_nx;
  logic [PLEN-1:0]   base_q;
  logic [PLEN-1:0]   addr_q;
  logic [PLEN-1:0]   line_base;
  logic [PLEN-1:0]   next_addr;
  logic [WAY_W-1:0]  way_q;
  logic [LINE_W-1:0] line_q;
  logic              ready_q;
  logic              mem_valid_q;
  logic              refill_valid_q;
  logic              unused_ok;

  assign line_base = {miss_req_paddr_i[PLEN-1:LB], {LB{1'b0}}};
  assign beat_nx   = beat_q + 1'b1;
  // Beat offsets stay inside the line, so this never crosses a line.
  assign next_addr = base_q + (PLEN'(beat_nx) << BB);
  assign unused_ok = ^{miss_req_paddr_i[LB-1:0], miss_req_index_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      beat_q         <= '0;
      base_q         <= '0;
      addr_q         <= '0;
      way_q          <= '0;
      line_q         <= '0;
      ready_q        <= 1'b0;
      mem_valid_q    <= 1'b0;
      refill_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (miss_req_valid_i && ready_q) begin
            ready_q     <= 1'b0;
            base_q      <= line_base;
            addr_q      <= line_base;
            way_q       <= miss_req_victim_way_i;
            beat_q      <= '0;
            line_q      <= '0;
            mem_valid_q <= 1'b1;
            state_q     <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            mem_valid_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (mem_rsp_valid_i) begin
            line_q[beat_q*MEM_DW +: MEM_DW] <= mem_rsp_data_i;
            if (beat_q == LAST) begin
              refill_valid_q <= 1'b1;
              state_q        <= RESP;
            end else begin
              beat_q      <= beat_nx;
              addr_q      <= next_addr;
              mem_valid_q <= 1'b1;
              state_q     <= REQ;
            end
          end
        end
        RESP: begin
          if (refill_ready_i) begin
            refill_valid_q <= 1'b0;
            ready_q        <= 1'b1;
            state_q        <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign miss_req_ready_o = ready_q;
  assign mem_req_valid_o  = mem_valid_q;
  assign mem_req_addr_o   = addr_q;
  assign refill_valid_o   = refill_valid_q;
  assign refill_paddr_o   = base_q;
  assign refill_way_o     = way_q;
  assign refill_data_o    = line_q;
  assign busy_o           = (state_q != IDLE);

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni && state_q == IDLE && miss_req_valid_i && ready_q)
      assert (miss_req_index_i == miss_req_paddr_i[LB +: INDEX_W]);
    if (rst_ni && state_q == WAIT && mem_rsp_valid_i)
      assert (!$isunknown(mem_rsp_data_i));
  end
`endif

endmodule

// File: tb/tb_icache_refill_responder.sv
// Bench for icache_refill_responder: table-driven and random misses
// checked against a line-level memory/refill model.
module tb_icache_refill_responder;
  localparam int PLEN    = 32;
  localparam int LINE_W  = 256;
  localparam int WAY_W   = 2;
  localparam int INDEX_W = 6;
  localparam int MEM_DW  = 32;
  localparam int BEATS   = LINE_W / MEM_DW;

  logic               clk_i = 1'b0;
  logic               rst_ni = 1'b0;
  logic               miss_req_valid_i = 1'b0;
  logic               miss_req_ready_o;
  logic [PLEN-1:0]    miss_req_paddr_i = '0;
  logic [WAY_W-1:0]   miss_req_victim_way_i = '0;
  logic [INDEX_W-1:0] miss_req_index_i = '0;
  logic               refill_valid_o;
  logic               refill_ready_i;
  logic [PLEN-1:0]    refill_paddr_o;
  logic [WAY_W-1:0]   refill_way_o;
  logic [LINE_W-1:0]  refill_data_o;
  logic               mem_req_valid_o;
  logic               mem_req_ready_i;
  logic [PLEN-1:0]    mem_req_addr_o;
  logic               mem_rsp_valid_i;
  logic [MEM_DW-1:0]  mem_rsp_data_i;
  logic               busy_o;

  always #5 clk_i = ~clk_i;

  icache_refill_responder dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .miss_req_valid_i      (miss_req_valid_i),
    .miss_req_ready_o      (miss_req_ready_o),
    .miss_req_paddr_i      (miss_req_paddr_i),
    .miss_req_victim_way_i (miss_req_victim_way_i),
    .miss_req_index_i      (miss_req_index_i),
    .refill_valid_o        (refill_valid_o),
    .refill_ready_i        (refill_ready_i),
    .refill_paddr_o        (refill_paddr_o),
    .refill_way_o          (refill_way_o),
    .refill_data_o         (refill_data_o),
    .mem_req_valid_o       (mem_req_valid_o),
    .mem_req_ready_i       (mem_req_ready_i),
    .mem_req_addr_o        (mem_req_addr_o),
    .mem_rsp_valid_i       (mem_rsp_valid_i),
    .mem_rsp_data_i        (mem_rsp_data_i),
    .busy_o                (busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory contents: a distinct word per address, xored with a salt so
  // data after a reset can be told apart from data before it.
  logic [31:0] salt = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + (((a >> 5) & 32'h7FF) << 8) + ((a >> 2) & 32'h7);
  endfunction

  typedef struct {
    logic [PLEN-1:0]   paddr;
    logic [WAY_W-1:0]  way;
    logic [LINE_W-1:0] data;
  } exp_t;

  exp_t            exp_q[$];
  logic [PLEN-1:0] addr_q[$];

  task automatic push_exp(input logic [31:0] pa, input logic [1:0] w);
    exp_t e;
    e.paddr = pa & ~32'h1F;
    e.way   = w;
    e.data  = '0;
    for (int k = 0; k < BEATS; k++) begin
      e.data[k*32 +: 32] = mem_word(e.paddr + 32'(4*k)) ^ salt;
      addr_q.push_back(e.paddr + 32'(4*k));
    end
    exp_q.push_back(e);
  endtask

  // Memory model
  int          ready_pct = 100;
  int          max_dly   = 0;
  bit          spur_en   = 0;
  bit          hs_armed  = 0;
  bit          rsp_pend  = 0;
  int          rsp_wait  = 0;
  int          beats_done = 0;
  logic [31:0] rsp_addr, armed_addr, prev_addr;
  bit          prev_stall = 0;

  initial begin
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        mem_req_ready_i = 1'($urandom);
        mem_rsp_valid_i = 1'($urandom);
        mem_rsp_data_i  = $urandom;
        hs_armed   = 0;
        rsp_pend   = 0;
        prev_stall = 0;
      end else begin
        mem_rsp_valid_i = 1'b0;
        if (hs_armed) begin
          hs_armed = 0;
          rsp_pend = 1;
          rsp_wait = $urandom_range(max_dly);
          rsp_addr = armed_addr;
        end
        if (rsp_pend) begin
          if (rsp_wait == 0) begin
            mem_rsp_valid_i = 1'b1;
            mem_rsp_data_i  = mem_word(rsp_addr) ^ salt;
            rsp_pend = 0;
            beats_done++;
          end else begin
            rsp_wait--;
          end
        end else if (spur_en && $urandom_range(2) == 0) begin
          mem_rsp_valid_i = 1'b1;
          mem_rsp_data_i  = $urandom;
        end
        if (prev_stall) begin
          check("mem_valid_held", mem_req_valid_o, 1);
          check("mem_addr_stable", mem_req_addr_o, prev_addr);
        end
        mem_req_ready_i = 1'b0;
        if (mem_req_valid_o && !rsp_pend &&
            $urandom_range(99) < ready_pct) begin
          mem_req_ready_i = 1'b1;
          hs_armed   = 1;
          armed_addr = mem_req_addr_o;
          if (addr_q.size() == 0)
            check("mem_req_unexpected", 1, 0);
          else
            check("mem_addr", mem_req_addr_o, addr_q.pop_front());
        end
        prev_stall = mem_req_valid_o && !mem_req_ready_i;
        prev_addr  = mem_req_addr_o;
      end
    end
  end

  // Refill monitor / ICache model
  int              hold_cfg = 0;
  int              hold_cnt = 0;
  int              hs_count = 0;
  int              last_hs_cyc = 0;
  int              hs_cyc[$];
  logic [PLEN-1:0] rf_paddr_q[$];
  bit              prev_rv = 0;
  logic [PLEN-1:0]   p_paddr;
  logic [WAY_W-1:0]  p_way;
  logic [LINE_W-1:0] p_data;

  initial begin
    exp_t e;
    refill_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        refill_ready_i = 1'($urandom);
        prev_rv = 0;
      end else begin
        if (prev_rv) begin
          check("refill_valid_held", refill_valid_o, 1);
          check("refill_paddr_stable", refill_paddr_o, p_paddr);
          check("refill_way_stable", refill_way_o, p_way);
          check("refill_data_stable", refill_data_o, p_data);
        end
        refill_ready_i = 1'b0;
        if (refill_valid_o) begin
          if (!prev_rv) hold_cnt = hold_cfg;
          if (hold_cnt > 0) begin
            hold_cnt--;
          end else begin
            refill_ready_i = 1'b1;
            if (exp_q.size() == 0) begin
              check("refill_unexpected", 1, 0);
            end else begin
              e = exp_q.pop_front();
              check("refill_paddr", refill_paddr_o, e.paddr);
              check("refill_way", refill_way_o, e.way);
              check("refill_data", refill_data_o, e.data);
            end
            hs_count++;
            last_hs_cyc = cyc + 1;
            hs_cyc.push_back(cyc + 1);
            rf_paddr_q.push_back(refill_paddr_o);
          end
        end
        prev_rv = refill_valid_o && !refill_ready_i;
        p_paddr = refill_paddr_o;
        p_way   = refill_way_o;
        p_data  = refill_data_o;
      end
    end
  end

  task automatic issue(input logic [31:0] pa, input logic [1:0] w,
                       output int acc);
    int n = 0;
    miss_req_valid_i      = 1'b1;
    miss_req_paddr_i      = pa;
    miss_req_victim_way_i = w;
    miss_req_index_i      = pa[10:5];
    acc = -1;
    while (acc < 0 && n < 3000) begin
      if (miss_req_ready_o) begin
        push_exp(pa, w);
        acc = cyc + 1;
      end
      @(negedge clk_i);
      n++;
    end
    if (acc < 0) check("miss_accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int n);
    int k = 0;
    while (hs_count < n && k < 3000) begin
      @(negedge clk_i);
      k++;
    end
    if (hs_count < n) check("refill_timeout", hs_count, n);
  endtask

  typedef struct {
    logic [31:0] pa;
    logic [1:0]  way;
    int          pct;
    int          dly;
    int          hold;
    bit          spur;
    logic [31:0] exp_pa;
    int          lat;
  } vec_t;

  initial begin
    vec_t        tbl[5];
    int          acc, acc1, acc2, exp_n, n0;
    logic [31:0] pa;
    logic [1:0]  w;

    tbl[0] = '{32'h8000_0014, 2'd2, 100, 0, 0,  1'b0, 32'h8000_0000, 17};
    tbl[1] = '{32'h8000_0014, 2'd2, 30,  5, 10, 1'b0, 32'h8000_0000, -1};
    tbl[2] = '{32'h1234_567F, 2'd1, 100, 0, 0,  1'b0, 32'h1234_5660, 17};
    tbl[3] = '{32'hFFFF_FFE4, 2'd3, 30,  3, 2,  1'b0, 32'hFFFF_FFE0, -1};
    tbl[4] = '{32'h0000_0100, 2'd0, 60,  2, 3,  1'b1, 32'h0000_0100, -1};
    exp_n = 0;

    // Reset with random inputs
    rst_ni = 1'b0;
    repeat (4) begin
      @(negedge clk_i);
      miss_req_valid_i      = 1'($urandom);
      miss_req_paddr_i      = $urandom;
      miss_req_victim_way_i = 2'($urandom);
      miss_req_index_i      = 6'($urandom);
      check("rst_refill_valid", refill_valid_o, 0);
      check("rst_mem_valid", mem_req_valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_ready", miss_req_ready_o, 0);
    end
    @(negedge clk_i);
    miss_req_valid_i = 1'b0;
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("post_rst_ready", miss_req_ready_o, 1);
    check("post_rst_busy", busy_o, 0);

    // Table-driven misses
    for (int i = 0; i < 5; i++) begin
      ready_pct = tbl[i].pct;
      max_dly   = tbl[i].dly;
      hold_cfg  = tbl[i].hold;
      spur_en   = tbl[i].spur;
      issue(tbl[i].pa, tbl[i].way, acc);
      miss_req_valid_i = 1'b0;
      exp_n++;
      wait_done(exp_n);
      check("tbl_refill_paddr", rf_paddr_q[$], tbl[i].exp_pa);
      if (tbl[i].lat >= 0)
        check("tbl_latency", last_hs_cyc - acc, tbl[i].lat);
    end

    // Spurious responses while idle
    spur_en = 1;
    repeat (6) begin
      @(negedge clk_i);
      check("spur_idle_busy", busy_o, 0);
      check("spur_idle_refill", refill_valid_o, 0);
      check("spur_idle_memreq", mem_req_valid_o, 0);
    end
    spur_en = 0;

    // Back-to-back misses with valid held high
    ready_pct = 100;
    max_dly   = 0;
    hold_cfg  = 2;
    issue(32'h0000_0100, 2'd1, acc1);
    issue(32'h0000_0140, 2'd3, acc2);
    miss_req_valid_i = 1'b0;
    exp_n += 2;
    wait_done(exp_n);
    check("b2b_accept_cycle", acc2, hs_cyc[exp_n-2] + 1);
    check("b2b_first_paddr", rf_paddr_q[exp_n-2], 32'h0000_0100);
    check("b2b_second_paddr", rf_paddr_q[exp_n-1], 32'h0000_0140);

    // Reset during beat 3 of 8
    hold_cfg = 0;
    n0 = beats_done;
    issue(32'h8000_0020, 2'd0, acc);
    miss_req_valid_i = 1'b0;
    for (int k = 0; k < 200 && beats_done < n0 + 3; k++)
      @(negedge clk_i);
    check("midbeat_reached", beats_done - n0, 3);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    exp_q.delete();
    addr_q.delete();
    hs_armed = 0;
    rsp_pend = 0;
    check("mid_rst_refill_valid", refill_valid_o, 0);
    check("mid_rst_mem_valid", mem_req_valid_o, 0);
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_ready", miss_req_ready_o, 0);
    check("mid_rst_mem_addr", mem_req_addr_o, 0);
    check("mid_rst_refill_paddr", refill_paddr_o, 0);
    check("mid_rst_refill_way", refill_way_o, 0);
    check("mid_rst_refill_data", refill_data_o, 0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    salt = 32'h5A5A_5A5A;
    repeat (3) @(negedge clk_i);
    check("no_refill_after_reset", hs_count, exp_n);
    issue(32'h8000_0014, 2'd1, acc);
    miss_req_valid_i = 1'b0;
    exp_n++;
    wait_done(exp_n);
    check("post_rst_latency", last_hs_cyc - acc, 17);

    // Random misses
    for (int r = 0; r < 16; r++) begin
      ready_pct = $urandom_range(100, 20);
      max_dly   = $urandom_range(5);
      hold_cfg  = $urandom_range(6);
      spur_en   = 1'($urandom);
      pa = $urandom;
      w  = 2'($urandom);
      issue(pa, w, acc);
      miss_req_valid_i = 1'b0;
      exp_n++;
      wait_done(exp_n);
    end
    spur_en = 0;

    repeat (4) @(negedge clk_i);
    check("exp_queue_empty", exp_q.size(), 0);
    check("refill_count", hs_count, exp_n);
    check("final_idle", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
